// File: rtl/kabeta_loader_pkg.sv
// -----------------------------------------------------------------------------
// kabeta_loader_pkg
//   Definitions shared by the instruction-memory loader:
//     - frame field widths (byte, word, count, memory word address)
//     - default frame start byte
//     - loader FSM state encoding (3-bit codes)
// -----------------------------------------------------------------------------
package kabeta_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned MEM_ADDR_W     = 29;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//   Bundles the loader's byte-stream input, instruction-memory write port and
//   CPU/load status lines.
//     RxData/RxValid  : byte from the debug UART receiver
//     RxReady         : loader accepts a byte this cycle (RxValid & RxReady)
//     MemWrEn/Addr/Data : one-cycle word write into instruction memory
//     CpuHold         : keep the CPU core in reset while a program loads
//     LoadDone        : last frame loaded with a good checksum
//     LoadError       : last frame aborted
//   Modports:
//     slave  - the loader itself
//     master - the environment (UART receiver + memory + CPU reset logic)
// -----------------------------------------------------------------------------
interface instr_mem_loader_if;
  import kabeta_loader_pkg::*;

  logic [BYTE_W-1:0]     RxData;
  logic                  RxValid;
  logic                  RxReady;
  logic                  MemWrEn;
  logic [MEM_ADDR_W-1:0] MemWrAddr;
  logic [WORD_W-1:0]     MemWrData;
  logic                  CpuHold;
  logic                  LoadDone;
  logic                  LoadError;

  modport slave (
    input  RxData, RxValid,
    output RxReady, MemWrEn, MemWrAddr, MemWrData, CpuHold, LoadDone, LoadError
  );

  modport master (
    output RxData, RxValid,
    input  RxReady, MemWrEn, MemWrAddr, MemWrData, CpuHold, LoadDone, LoadError
  );

endinterface

// File: rtl/loader_gap_timer.sv
// -----------------------------------------------------------------------------
// loader_gap_timer
//   Counts idle cycles between accepted bytes inside a frame.
//     Clock     : system clock
//     SysReset  : asynchronous active-low reset
//     clr_i     : a byte was accepted this cycle; restart the count
//     en_i      : loader is inside a frame; count while high, hold at 0 otherwise
//     expired_o : this cycle is the LIMIT-th consecutive idle cycle
//   The counter saturates once expired so it can never wrap back to a
//   "fresh" value while the enable is still high.
// -----------------------------------------------------------------------------
module loader_gap_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic Clock,
  input  logic SysReset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Counter holds the number of idle cycles already completed, so the idle
  // cycle in progress is number cnt_q+1.
  assign expired_o = en_i && !clr_i && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    // NOTE: next-state defaults to the current value before any branch, so
    // no path through this block leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Write-side companion of the instruction memory. Parses a byte stream
//     SYNC, CNT_LO, CNT_HI, CNT x 4 data bytes (little-endian words), CHK
//   where CHK is the XOR of all data bytes, and writes each assembled word
//   into the instruction memory. The CPU is held in reset while loading.
//   Ports:
//     Clock    : system clock
//     SysReset : asynchronous active-low reset
//     bus      : byte stream in, memory write port and status out
//   Parameters:
//     ADDR_WIDTH    : word-address bits of the target memory
//     SYNC_BYTE     : frame start byte
//     TIMEOUT_CYC   : idle cycles allowed between bytes inside a frame
//     HOLD_AT_RESET : CpuHold value coming out of reset
// -----------------------------------------------------------------------------
module instr_mem_loader
  import kabeta_loader_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH    = 8,
  parameter logic [BYTE_W-1:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int unsigned       TIMEOUT_CYC   = 1000000,
  parameter bit                HOLD_AT_RESET = 1'b1
) (
  input  logic              Clock,
  input  logic              SysReset,
  instr_mem_loader_if.slave bus
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_t                  state_q, state_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    load_done_q, load_done_d;
  logic                    load_error_q, load_error_d;
  logic [BYTE_W-1:0]       chk_q, chk_d;
  logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
  logic [BYTE_W-1:0]       cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]        words_left_q, words_left_d;

  logic                    rx_accept;
  logic                    gap_en;
  logic                    gap_expired;
  logic                    go_error;
  logic [CNT_W-1:0]        cnt_full;

  assign rx_accept = bus.RxValid && rx_ready_q;
  assign cnt_full  = {bus.RxData, cnt_lo_q};
  assign gap_en    = state_q inside {ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CHECK};

  loader_gap_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_gap_timer (
    .Clock     (Clock),
    .SysReset  (SysReset),
    .clr_i     (rx_accept),
    .en_i      (gap_en),
    .expired_o (gap_expired)
  );

  always_comb begin
    state_d      = state_q;
    rx_ready_d   = 1'b1;
    mem_wr_en_d  = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    chk_d        = chk_q;
    byte_idx_d   = byte_idx_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    go_error     = 1'b0;

    // The address advances at the end of the write cycle, so the strobe
    // always carries the address of the word being written.
    if (mem_wr_en_q) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      // ERROR parses bytes exactly like IDLE; only the status levels differ.
      ST_IDLE, ST_ERROR: begin
        if (rx_accept && bus.RxData == SYNC_BYTE) begin
          state_d      = ST_CNT_LO;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          chk_d        = '0;
          byte_idx_d   = '0;
          addr_d       = '0;
        end
      end

      ST_CNT_LO: begin
        if (rx_accept) begin
          cnt_lo_d = bus.RxData;
          state_d  = ST_CNT_HI;
        end else if (gap_expired) begin
          go_error = 1'b1;
        end
      end

      ST_CNT_HI: begin
        if (rx_accept) begin
          if (32'(cnt_full) > MAX_WORDS) begin
            go_error = 1'b1;
          end else if (cnt_full == '0) begin
            state_d = ST_CHECK;
          end else begin
            words_left_d = cnt_full;
            state_d      = ST_DATA;
          end
        end else if (gap_expired) begin
          go_error = 1'b1;
        end
      end

      ST_DATA: begin
        if (rx_accept) begin
          data_d[byte_idx_q*BYTE_W +: BYTE_W] = bus.RxData;
          chk_d      = chk_q ^ bus.RxData;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == LAST_IDX) begin
            // Write next cycle; the stall keeps the word stable while the
            // memory samples it.
            mem_wr_en_d  = 1'b1;
            rx_ready_d   = 1'b0;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == CNT_W'(1)) begin
              state_d = ST_CHECK;
            end
          end
        end else if (gap_expired) begin
          go_error = 1'b1;
        end
      end

      ST_CHECK: begin
        if (rx_accept) begin
          if (bus.RxData == chk_q) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            go_error = 1'b1;
          end
        end else if (gap_expired) begin
          go_error = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // CpuHold is deliberately left asserted: a half-loaded program must not run.
    if (go_error) begin
      state_d      = ST_ERROR;
      load_error_d = 1'b1;
      load_done_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_hold_q   <= HOLD_AT_RESET;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      chk_q        <= '0;
      byte_idx_q   <= '0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      mem_wr_en_q  <= mem_wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      chk_q        <= chk_d;
      byte_idx_q   <= byte_idx_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
    end
  end

  assign bus.RxReady   = rx_ready_q;
  assign bus.MemWrEn   = mem_wr_en_q;
  assign bus.MemWrAddr = MEM_ADDR_W'(addr_q);
  assign bus.MemWrData = data_q;
  assign bus.CpuHold   = cpu_hold_q;
  assign bus.LoadDone  = load_done_q;
  assign bus.LoadError = load_error_q;

endmodule
